// File: rtl/core_pkg.sv
// Shared constants and types for the RV32I pipeline front end.
package core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_WORD   = 32'h0000_0013;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_HOLD,
        PC_REDIRECT
    } pc_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcPlus4;
        logic            valid;
    } ifid_t;

    function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
        return (v == {XLEN{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register with hold (stall) and bubble insertion (flush).
// Flush outranks stall; reset loads the bubble value.
module if_id_reg #(
    parameter int unsigned    W      = 32,
    parameter logic [W-1:0]   BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall_i,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q;
    logic [W-1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (flush_i) begin
            stage_d = BUBBLE;
        end else if (!stall_i) begin
            stage_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/fetch_if_id_stage.sv
// Fetch stage (PC register, +4 adder, next-PC mux) and IF/ID register of the RV32I core.
// Optional IF_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_if_id_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_WORD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] instrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            validD
`ifdef IF_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_stall
`endif
);

    localparam ifid_t BUBBLE_D = '{instr: NOP_INSTR, pc: '0, pcPlus4: '0, valid: 1'b0};

    logic [XLEN-1:0] pcF_q;
    logic [XLEN-1:0] pcF_d;
    logic [XLEN-1:0] pcPlus4F;
    pc_sel_e         pcSel;
    ifid_t           captureD;
    ifid_t           ifidQ;

    assign pcPlus4F = pcF_q + 32'd4;

    // A redirect outranks StallF so the wrong-path fetch is never held.
    always_comb begin
        if (PCSrcE) begin
            pcSel = PC_REDIRECT;
        end else if (StallF) begin
            pcSel = PC_HOLD;
        end else begin
            pcSel = PC_SEQ;
        end
    end

    always_comb begin
        pcF_d = pcPlus4F;
        case (pcSel)
            PC_REDIRECT: pcF_d = PCTargetE & ~32'd3;
            PC_HOLD:     pcF_d = pcF_q;
            default:     pcF_d = pcPlus4F;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcF_q <= RESET_PC;
        end else begin
            pcF_q <= pcF_d;
        end
    end

    assign PCF       = pcF_q;
    assign imem_addr = pcF_q;

    assign captureD = '{instr: imem_rdata, pc: pcF_q, pcPlus4: pcPlus4F, valid: 1'b1};

    if_id_reg #(
        .W      ($bits(ifid_t)),
        .BUBBLE (BUBBLE_D)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall_i (StallD),
        .flush_i (FlushD),
        .d_i     (captureD),
        .q_o     (ifidQ)
    );

    assign instrD   = ifidQ.instr;
    assign PCD      = ifidQ.pc;
    assign PCPlus4D = ifidQ.pcPlus4;
    assign validD   = ifidQ.valid;

`ifdef IF_PERF_CNT_EN
    logic [XLEN-1:0] perfFetched_q;
    logic [XLEN-1:0] perfFetched_d;
    logic [XLEN-1:0] perfStall_q;
    logic [XLEN-1:0] perfStall_d;

    // Stall cycles only count when no redirect overrides the PC hold.
    always_comb begin
        perfFetched_d = perfFetched_q;
        perfStall_d   = perfStall_q;
        if (!FlushD && !StallD) begin
            perfFetched_d = sat_inc(perfFetched_q);
        end
        if (StallF && !PCSrcE) begin
            perfStall_d = sat_inc(perfStall_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfFetched_q <= '0;
            perfStall_q   <= '0;
        end else begin
            perfFetched_q <= perfFetched_d;
            perfStall_q   <= perfStall_d;
        end
    end

    assign perf_fetched = perfFetched_q;
    assign perf_stall   = perfStall_q;
`endif

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Self-checking bench for fetch_if_id_stage: directed scenarios then randomized traffic
// against a behavioural model of the fetch PC and IF/ID contents.
module tb_fetch_if_id_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PCF, instrD, PCD, PCPlus4D;
    logic        validD;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mPc, mInstr, mPcD, mPc4D, mFetched, mStallCnt;
    logic        mValid;

    always #5 clk = ~clk;

    function automatic logic [31:0] imemWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = imemWord(imem_addr);

    fetch_if_id_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .PCF        (PCF),
        .instrD     (instrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .validD     (validD)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        mPc       = 32'h0000_0000;
        mInstr    = 32'h0000_0013;
        mPcD      = 32'h0;
        mPc4D     = 32'h0;
        mValid    = 1'b0;
        mFetched  = 32'h0;
        mStallCnt = 32'h0;
    endtask

    function automatic logic [31:0] satPlus1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic checkOutput(input string tag);
        checkEq({tag, ".PCF"},       PCF,       mPc);
        checkEq({tag, ".imem_addr"}, imem_addr, mPc);
        checkEq({tag, ".instrD"},    instrD,    mInstr);
        checkEq({tag, ".PCD"},       PCD,       mPcD);
        checkEq({tag, ".PCPlus4D"},  PCPlus4D,  mPc4D);
        checkEq({tag, ".validD"},    {31'b0, validD}, {31'b0, mValid});
`ifdef IF_PERF_CNT_EN
        checkEq({tag, ".perf_fetched"}, perf_fetched, mFetched);
        checkEq({tag, ".perf_stall"},   perf_stall,   mStallCnt);
`endif
    endtask

    // Drives one cycle of hazard inputs, advances the model at the edge, then checks.
    task automatic applyStimulus(input string tag, input logic sF, input logic sD,
                                 input logic fD, input logic src, input logic [31:0] tgt);
        logic [31:0] oldPc;
        StallF    = sF;
        StallD    = sD;
        FlushD    = fD;
        PCSrcE    = src;
        PCTargetE = tgt;
        @(posedge clk);
        oldPc = mPc;
        if (fD) begin
            mInstr = 32'h0000_0013;
            mPcD   = 32'h0;
            mPc4D  = 32'h0;
            mValid = 1'b0;
        end else if (!sD) begin
            mInstr   = imemWord(oldPc);
            mPcD     = oldPc;
            mPc4D    = oldPc + 32'd4;
            mValid   = 1'b1;
            mFetched = satPlus1(mFetched);
        end
        if (src) begin
            mPc = {tgt[31:2], 2'b00};
        end else if (!sF) begin
            mPc = oldPc + 32'd4;
        end
        if (sF && !src) begin
            mStallCnt = satPlus1(mStallCnt);
        end
        #1;
        checkOutput(tag);
    endtask

    initial begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'h0;
        rst_n     = 1'b1;
        resetModel();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset");
        checkEq("reset.instrNop", instrD, 32'h0000_0013);

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("boot0", 0, 0, 0, 0, 32'h0);
        checkEq("boot0.instrAt0", instrD, imemWord(32'h0));
        applyStimulus("boot1", 0, 0, 0, 0, 32'h0);
        checkEq("boot1.PCF", PCF, 32'h8);
        applyStimulus("seq2", 0, 0, 0, 0, 32'h0);
        applyStimulus("seq3", 0, 0, 0, 0, 32'h0);
        checkEq("preStall.PCF", PCF, 32'h10);

        applyStimulus("stall0", 1, 1, 0, 0, 32'h0);
        applyStimulus("stall1", 1, 1, 0, 0, 32'h0);
        checkEq("stall.PCD", PCD, 32'hC);
        applyStimulus("resume", 0, 0, 0, 0, 32'h0);
        checkEq("resume.PCF", PCF, 32'h14);

        applyStimulus("redirect", 0, 0, 1, 1, 32'h100);
        checkEq("redirect.PCF", PCF, 32'h100);
        applyStimulus("postRedir", 0, 0, 0, 0, 32'h0);
        checkEq("postRedir.PCPlus4D", PCPlus4D, 32'h104);

        applyStimulus("priority", 1, 1, 1, 1, 32'h40);
        checkEq("priority.PCF", PCF, 32'h40);
        checkEq("priority.validD", {31'b0, validD}, 32'h0);

        applyStimulus("toTop", 0, 0, 1, 1, 32'hFFFF_FFFC);
        applyStimulus("wrap", 0, 0, 0, 0, 32'h0);
        checkEq("wrap.PCF", PCF, 32'h0);
        checkEq("wrap.PCPlus4D", PCPlus4D, 32'h0);
        applyStimulus("align", 0, 0, 1, 1, 32'h203);
        checkEq("align.PCF", PCF, 32'h200);

        for (int i = 0; i < 300; i++) begin
            logic rSrc;
            rSrc = ($urandom_range(0, 9) == 0);
            applyStimulus("random",
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 5) == 0),
                          rSrc | ($urandom_range(0, 15) == 0),
                          rSrc,
                          $urandom);
        end

        #2 rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput("asyncRst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus("perfSeq", 0, 0, 0, 0, 32'h0);
        end
        applyStimulus("perfStall0", 1, 1, 0, 0, 32'h0);
        applyStimulus("perfStall1", 1, 1, 0, 0, 32'h0);
        applyStimulus("perfResume", 0, 0, 0, 0, 32'h0);
        checkEq("perfResume.PCF", PCF, 32'h14);
`ifdef IF_PERF_CNT_EN
        checkEq("perf.fetchedTotal", perf_fetched, 32'd5);
        checkEq("perf.stallTotal",   perf_stall,   32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
